// File: rtl/hpdmc_dataseq_if.sv
// ----------------------------------------------------------------------------
// hpdmc_dataseq_if
// Bundles the command/timing inputs and the datapath/safety outputs of the
// HPDMC data sequencer.
//   read, write      : single-cycle READ / WRITE (BL8) command strobes
//   tim_cas          : CAS latency select (0 -> CL2, 1 -> CL3)
//   tim_wr           : write recovery, 0..3 extra cycles
//   op_write/op_read : DDR I/O datapath enables, 4 cycles per burst
//   *_safe           : command may be issued this cycle
//   rburst_done      : pulse after each read burst
//   proto_err        : sticky protocol-violation flag
// master = command issuer, slave = sequencer.
// ----------------------------------------------------------------------------
interface hpdmc_dataseq_if;
  logic       read;
  logic       write;
  logic       tim_cas;
  logic [1:0] tim_wr;
  logic       op_write;
  logic       op_read;
  logic       read_safe;
  logic       write_safe;
  logic       precharge_safe;
  logic       rburst_done;
  logic       proto_err;

  modport master (
    output read, write, tim_cas, tim_wr,
    input  op_write, op_read, read_safe, write_safe, precharge_safe,
           rburst_done, proto_err
  );

  modport slave (
    input  read, write, tim_cas, tim_wr,
    output op_write, op_read, read_safe, write_safe, precharge_safe,
           rburst_done, proto_err
  );
endinterface

// File: rtl/hpdmc_dataseq.sv
// ----------------------------------------------------------------------------
// hpdmc_dataseq
// Sequences the DDR datapath for BL8 READ/WRITE commands and tracks the
// command hold-off windows that follow them.
// Ports:
//   clk  : system clock (posedge)
//   rst  : synchronous active-high reset
//   bus  : hpdmc_dataseq_if.slave (commands, timing, datapath/safe outputs)
// Optional feature: define HPDMC_DATASEQ_CHECK_EN to build the protocol
// checker driving proto_err; otherwise proto_err is tied low.
// All outputs come straight from registers.
// ----------------------------------------------------------------------------
module hpdmc_dataseq (
  input logic            clk,
  input logic            rst,
  hpdmc_dataseq_if.slave bus
);

  // A simultaneous read and write resolves to the read.
  logic       rd_cmd_s;
  logic       wr_cmd_s;

  // rd_dly_r[1] holds CL3 reads one extra cycle; rd_dly_r[0] means
  // "burst starts next cycle".
  logic [1:0] rd_dly_r;
  logic       op_read_r;
  logic [1:0] rd_rem_r;
  logic       rburst_done_r;
  logic       op_write_r;
  logic [1:0] wr_rem_r;

  // Hold-off counters: number of remaining cycles the safe output is low.
  logic [2:0] rs_cnt_r;
  logic [2:0] ws_cnt_r;
  logic [2:0] ps_cnt_r;
  logic [2:0] rs_nxt_s;
  logic [2:0] ws_nxt_s;
  logic [2:0] ps_nxt_s;
  logic [2:0] rs_val_s;
  logic [2:0] ws_val_s;
  logic [2:0] ps_val_s;
  logic       read_safe_r;
  logic       write_safe_r;
  logic       precharge_safe_r;

  // Count down (saturating at zero), then extend to the new window if a
  // command loads a longer one; an in-progress window is never shortened.
  function automatic logic [2:0] holdoff_next(input logic [2:0] cur,
                                              input logic       load,
                                              input logic [2:0] val);
    logic [2:0] dec;
    dec = (cur != 3'd0) ? (cur - 3'd1) : 3'd0;
    if (load && (val > dec)) begin
      return val;
    end else begin
      return dec;
    end
  endfunction

  assign rd_cmd_s = bus.read;
  assign wr_cmd_s = bus.write & ~bus.read;

  // Hold-off window lengths loaded by the current command.
  always_comb begin
    rs_val_s = 3'd0;
    ws_val_s = 3'd0;
    ps_val_s = 3'd0;
    if (rd_cmd_s) begin
      rs_val_s = 3'd3;
      ws_val_s = bus.tim_cas ? 3'd6 : 3'd5;
      ps_val_s = 3'd3;
    end else if (wr_cmd_s) begin
      rs_val_s = 3'd5;
      ws_val_s = 3'd3;
      ps_val_s = {1'b0, bus.tim_wr} + 3'd4;
    end else begin
      rs_val_s = 3'd0;
      ws_val_s = 3'd0;
      ps_val_s = 3'd0;
    end
  end

  // Next hold-off counter values.
  always_comb begin
    rs_nxt_s = holdoff_next(rs_cnt_r, rd_cmd_s | wr_cmd_s, rs_val_s);
    ws_nxt_s = holdoff_next(ws_cnt_r, rd_cmd_s | wr_cmd_s, ws_val_s);
    ps_nxt_s = holdoff_next(ps_cnt_r, rd_cmd_s | wr_cmd_s, ps_val_s);
  end

  // Hold-off counters and registered safe flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      rs_cnt_r         <= 3'd0;
      ws_cnt_r         <= 3'd0;
      ps_cnt_r         <= 3'd0;
      read_safe_r      <= 1'b1;
      write_safe_r     <= 1'b1;
      precharge_safe_r <= 1'b1;
    end else begin
      rs_cnt_r         <= rs_nxt_s;
      ws_cnt_r         <= ws_nxt_s;
      ps_cnt_r         <= ps_nxt_s;
      read_safe_r      <= (rs_nxt_s == 3'd0);
      write_safe_r     <= (ws_nxt_s == 3'd0);
      precharge_safe_r <= (ps_nxt_s == 3'd0);
    end
  end

  // Read pipeline: CAS delay line, 4-cycle op_read burst, done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_dly_r      <= 2'b00;
      op_read_r     <= 1'b0;
      rd_rem_r      <= 2'd0;
      rburst_done_r <= 1'b0;
    end else begin
      rd_dly_r[1] <= rd_cmd_s & bus.tim_cas;
      rd_dly_r[0] <= rd_dly_r[1] | (rd_cmd_s & ~bus.tim_cas);
      if (rd_dly_r[0]) begin
        // A back-to-back read restarts the burst on the cycle the previous
        // one would have ended, so op_read stays high without a gap.
        op_read_r <= 1'b1;
        rd_rem_r  <= 2'd3;
      end else if (rd_rem_r != 2'd0) begin
        op_read_r <= 1'b1;
        rd_rem_r  <= rd_rem_r - 2'd1;
      end else begin
        op_read_r <= 1'b0;
        rd_rem_r  <= 2'd0;
      end
      // Last op_read cycle of a burst is op_read high with nothing remaining.
      rburst_done_r <= op_read_r & (rd_rem_r == 2'd0);
    end
  end

  // Write pipeline: 4-cycle op_write burst starting the cycle after WRITE.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_write_r <= 1'b0;
      wr_rem_r   <= 2'd0;
    end else if (wr_cmd_s) begin
      op_write_r <= 1'b1;
      wr_rem_r   <= 2'd3;
    end else if (wr_rem_r != 2'd0) begin
      op_write_r <= 1'b1;
      wr_rem_r   <= wr_rem_r - 2'd1;
    end else begin
      op_write_r <= 1'b0;
      wr_rem_r   <= 2'd0;
    end
  end

`ifdef HPDMC_DATASEQ_CHECK_EN
  logic proto_err_r;

  // Sticky flag for commands issued outside their safe window or together.
  always_ff @(posedge clk) begin
    if (rst) begin
      proto_err_r <= 1'b0;
    end else if ((bus.read & ~read_safe_r) |
                 (bus.write & ~write_safe_r) |
                 (bus.read & bus.write)) begin
      proto_err_r <= 1'b1;
    end else begin
      proto_err_r <= proto_err_r;
    end
  end

  assign bus.proto_err = proto_err_r;
`else
  assign bus.proto_err = 1'b0;
`endif

  assign bus.op_read        = op_read_r;
  assign bus.op_write       = op_write_r;
  assign bus.rburst_done    = rburst_done_r;
  assign bus.read_safe      = read_safe_r;
  assign bus.write_safe     = write_safe_r;
  assign bus.precharge_safe = precharge_safe_r;

endmodule

// File: tb/tb_hpdmc_dataseq.sv
// ----------------------------------------------------------------------------
// tb_hpdmc_dataseq
// Self-checking bench for hpdmc_dataseq. Each table entry describes up to two
// commands plus hand-computed burst/pulse totals; a per-cycle expectation is
// derived from the command timing windows, queued as stimulus is driven and
// compared as the DUT output for that cycle is sampled. Hand-written
// sequences cover reset state and reset in the middle of a burst.
// ----------------------------------------------------------------------------
module tb_hpdmc_dataseq;

  localparam int T = 26;

`ifdef HPDMC_DATASEQ_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  hpdmc_dataseq_if bus ();

  hpdmc_dataseq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // kind: 0 none, 1 read, 2 write, 3 read+write
  typedef struct packed {
    logic       cas;
    logic [1:0] twr;
    logic [4:0] c0;
    logic [1:0] k0;
    logic [4:0] c1;
    logic [1:0] k1;
    logic [3:0] n_rd;
    logic [3:0] n_wr;
    logic [1:0] n_done;
    logic       perr;
  } vec_t;

  vec_t       vecs [8];
  logic [6:0] exp_q [$];
  logic [6:0] model [T];
  int         errors = 0;
  int         checks = 0;

  // Output vector order: {op_read, op_write, rburst_done, read_safe,
  // write_safe, precharge_safe, proto_err}
  function automatic logic [6:0] cur_out();
    return {bus.op_read, bus.op_write, bus.rburst_done, bus.read_safe,
            bus.write_safe, bus.precharge_safe, bus.proto_err};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Expected per-cycle outputs from the command timing windows.
  task automatic build_model(input vec_t v);
    int         cyc [2];
    logic [1:0] kind [2];
    int         cl;
    int         n;
    logic       perr;
    logic       ord, owr, dn, rs, ws, ps;
    cyc[0]  = int'(v.c0);
    cyc[1]  = int'(v.c1);
    kind[0] = v.k0;
    kind[1] = v.k1;
    cl      = v.cas ? 3 : 2;
    perr    = 1'b0;
    for (int c = 0; c < T; c++) begin
      ord = 1'b0; owr = 1'b0; dn = 1'b0; rs = 1'b1; ws = 1'b1; ps = 1'b1;
      for (int i = 0; i < 2; i++) begin
        n = cyc[i];
        if (kind[i][0]) begin
          if (c >= n + cl && c <= n + cl + 3) ord = 1'b1;
          if (c == n + cl + 4) dn = 1'b1;
          if (c >= n + 1 && c <= n + 3) begin rs = 1'b0; ps = 1'b0; end
          if (c >= n + 1 && c <= n + cl + 3) ws = 1'b0;
        end else if (kind[i][1]) begin
          if (c >= n + 1 && c <= n + 4) owr = 1'b1;
          if (c >= n + 1 && c <= n + 3) ws = 1'b0;
          if (c >= n + 1 && c <= n + 5) rs = 1'b0;
          if (c >= n + 1 && c <= n + 4 + int'(v.twr)) ps = 1'b0;
        end
      end
      model[c] = {ord, owr, dn, rs, ws, ps, perr};
      for (int i = 0; i < 2; i++) begin
        if (cyc[i] == c && CHK) begin
          if (kind[i] == 2'd3 || (kind[i] == 2'd1 && !rs) || (kind[i] == 2'd2 && !ws))
            perr = 1'b1;
        end
      end
    end
  endtask

  // Leaves the bench at the negedge of the first cycle after reset.
  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    bus.read  = 1'b0;
    bus.write = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int         nrd, nwr, ndn;
    logic [6:0] got, exp;
    build_model(v);
    bus.tim_cas = v.cas;
    bus.tim_wr  = v.twr;
    do_reset();
    nrd = 0; nwr = 0; ndn = 0;
    exp_q.push_back(model[0]);
    for (int c = 0; c < T; c++) begin
      got = cur_out();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL vec%0d cycle%0d outputs: got=%b expected=%b", idx, c, got, exp);
      end
      nrd += int'(got[6]);
      nwr += int'(got[5]);
      ndn += int'(got[4]);
      bus.read  = (v.k0[0] && int'(v.c0) == c) || (v.k1[0] && int'(v.c1) == c);
      bus.write = (v.k0[1] && int'(v.c0) == c) || (v.k1[1] && int'(v.c1) == c);
      if (c + 1 < T) exp_q.push_back(model[c + 1]);
      @(negedge clk);
    end
    bus.read  = 1'b0;
    bus.write = 1'b0;
    chk($sformatf("vec%0d op_read_cycles", idx), nrd, {28'd0, v.n_rd});
    chk($sformatf("vec%0d op_write_cycles", idx), nwr, {28'd0, v.n_wr});
    chk($sformatf("vec%0d rburst_done_pulses", idx), ndn, {30'd0, v.n_done});
    chk($sformatf("vec%0d proto_err_final", idx), {31'd0, bus.proto_err}, {31'd0, v.perr & CHK});
  endtask

  initial begin
    rst         = 1'b1;
    bus.read    = 1'b0;
    bus.write   = 1'b0;
    bus.tim_cas = 1'b0;
    bus.tim_wr  = 2'd0;

    //          cas   twr   c0     k0    c1     k1    n_rd  n_wr  n_done perr
    vecs[0] = '{1'b0, 2'd0, 5'd10, 2'd1, 5'd0,  2'd0, 4'd4, 4'd0, 2'd1, 1'b0};
    vecs[1] = '{1'b1, 2'd0, 5'd10, 2'd1, 5'd14, 2'd1, 4'd8, 4'd0, 2'd2, 1'b0};
    vecs[2] = '{1'b0, 2'd2, 5'd10, 2'd2, 5'd0,  2'd0, 4'd0, 4'd4, 2'd0, 1'b0};
    vecs[3] = '{1'b0, 2'd0, 5'd10, 2'd3, 5'd0,  2'd0, 4'd4, 4'd0, 2'd1, 1'b1};
    vecs[4] = '{1'b0, 2'd0, 5'd10, 2'd2, 5'd12, 2'd2, 4'd0, 4'd6, 2'd0, 1'b1};
    vecs[5] = '{1'b1, 2'd3, 5'd5,  2'd2, 5'd11, 2'd1, 4'd4, 4'd4, 2'd1, 1'b0};
    vecs[6] = '{1'b1, 2'd1, 5'd3,  2'd1, 5'd10, 2'd2, 4'd4, 4'd4, 2'd1, 1'b0};
    vecs[7] = '{1'b0, 2'd1, 5'd2,  2'd2, 5'd4,  2'd1, 4'd4, 4'd4, 2'd1, 1'b1};

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Reset state, then write at cycle 10 interrupted by reset at cycle 12
    // (with a read presented during the reset cycle, which must be dropped).
    bus.tim_cas = 1'b0;
    bus.tim_wr  = 2'd3;
    do_reset();
    chk("reset_state", {25'd0, cur_out()}, {25'd0, 7'b0001110});
    repeat (10) @(negedge clk);
    bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
    chk("write_started", {25'd0, cur_out()}, {25'd0, 7'b0100000});
    @(negedge clk);
    rst      = 1'b1;
    bus.read = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    bus.read = 1'b0;
    chk("rst_mid_burst", {25'd0, cur_out()}, {25'd0, 7'b0001110});
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("post_rst_idle%0d", c), {25'd0, cur_out()}, {25'd0, 7'b0001110});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hpdmc_dataseq.md
HPDMC_DATASEQ -- requirements
Module: hpdmc_dataseq

Interface
REQ-001 clk  input  1  system clock; all logic on posedge clk; one clock domain.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 read  input  1  READ command (BL8) presented to SDRAM this cycle; single-cycle pulse.
REQ-004 write  input  1  WRITE command (BL8) presented to SDRAM this cycle; single-cycle pulse.
REQ-005 tim_cas  input  1  CAS latency select; 0 -> CL=2, 1 -> CL=3; static while read/write idle.
REQ-006 tim_wr  input  2  write recovery, 0..3 extra cycles after last write data.
REQ-007 op_write  output  1  to DDR I/O write datapath; high 4 cycles per write burst.
REQ-008 op_read  output  1  to DDR I/O read datapath; high 4 cycles per read burst.
REQ-009 read_safe  output  1  a READ may be issued this cycle.
REQ-010 write_safe  output  1  a WRITE may be issued this cycle.
REQ-011 precharge_safe  output  1  PRECHARGE may be issued this cycle.
REQ-012 rburst_done  output  1  one-cycle pulse after each read burst's last op_read cycle.
REQ-013 proto_err  output  1  sticky protocol-violation flag (see Configuration).

Function
REQ-014 All outputs driven directly from registers; no combinational path from inputs to outputs.
REQ-015 write at cycle N: op_write high cycles N+1..N+4.
REQ-016 read at cycle N: op_read high cycles N+CL..N+CL+3; CL sampled at N.
REQ-017 Read pipeline holds two overlapping reads: read at N and N+4 gives continuous op_read N+CL..N+CL+7, no gap.
REQ-018 Write pipeline: write at N and N+4 gives continuous op_write N+1..N+8.
REQ-019 rburst_done high cycle N+CL+4 for each read at N; back-to-back reads give two pulses 4 cycles apart.
REQ-020 After read at N: read_safe low N+1..N+3; write_safe low N+1..N+CL+3; precharge_safe low N+1..N+3.
REQ-021 After write at N: write_safe low N+1..N+3; read_safe low N+1..N+5; precharge_safe low N+1..N+4+tim_wr.
REQ-022 Each safe output is the AND of all outstanding hold-offs; a new command reloads only its own counters to the larger of current and new value (never shortens).
REQ-023 read and write in same cycle: read executes, write ignored.
REQ-024 A command issued while its safe output is low still executes per REQ-015/016 (hold-off counters per REQ-022).
REQ-025 Hold-off counters saturate at 0; no wrap-around.

Reset
REQ-026 rst high: op_read=0, op_write=0, rburst_done=0, proto_err=0, read_safe=1, write_safe=1, precharge_safe=1 on the next edge.
REQ-027 rst mid-burst aborts all pending bursts; no op_read/op_write/rburst_done after reset deasserts without a new command.
REQ-028 read/write sampled in a cycle with rst high is ignored.

Configuration
REQ-029 Macro HPDMC_DATASEQ_CHECK_EN defined: proto_err set (sticky until rst) the cycle after read while read_safe=0, write while write_safe=0, or read and write together.
REQ-030 Macro undefined: proto_err tied to 0, checker logic absent; all other behaviour identical.

Verification
REQ-031 tim_cas=0, read at cycle 10 -> op_read high 12..15, rburst_done at 16, read_safe low 11..13, write_safe low 11..15.
REQ-032 tim_cas=1, reads at 10 and 14 -> op_read high 13..20 continuous, rburst_done at 17 and 21.
REQ-033 tim_wr=2, write at 10 -> op_write high 11..14, read_safe low 11..15, precharge_safe low 11..16, high at 17.
REQ-034 read and write both at 10 (CHECK_EN defined) -> only read burst generated, proto_err=1 from 11 until rst.
REQ-035 write at 10, rst at 12 -> op_write low from 13, all safes high from 13, no op_write afterwards.
REQ-036 write at 10 then write at 12 (unsafe, CHECK_EN) -> op_write high 11..16, proto_err=1 from 13; CHECK_EN undefined -> proto_err stays 0.
